// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: owner-state encoding and funct3 size codes
// shared by the memory arbiter files.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    OWN_IF = 2'b01,
    OWN_D  = 2'b10
  } owner_e;

  localparam logic [2:0] F3_B = 3'd0;
  localparam logic [2:0] F3_H = 3'd1;
  localparam logic [2:0] F3_W = 3'd2;

endpackage

// File: rtl/mem_arb_align_chk.sv
// mem_arb_align_chk: flags a load/store whose address is not
// naturally aligned to its access size (funct3 low bits).
module mem_arb_align_chk
  import mem_arb_pkg::*;
(
  input  logic [1:0] sz,
  input  logic [1:0] addr,
  output logic       misaligned
);

  // halfword needs addr[0]=0, word needs addr[1:0]=0
  always_comb begin
    misaligned = 1'b0;
    unique case (1'b1)
      (sz == F3_H[1:0]): misaligned = addr[0];
      (sz == F3_W[1:0]): misaligned = |addr;
      default:           misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and
// load/store. Define MEM_ARB_RR_EN for round-robin conflicts.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_f3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_f3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  owner_e owner_q, owner_d;
  logic mis, d_ok, d_bad;
  logic if_win, d_win;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0] f3_q;

  mem_arb_align_chk u_chk (
    .sz        (d_f3[1:0]),
    .addr      (d_addr[1:0]),
    .misaligned(mis)
  );

  assign d_ok  = d_req & ~mis;
  assign d_bad = d_req & mis;

`ifdef MEM_ARB_RR_EN
  logic rr_d_q;
  logic conflict;

  assign conflict = if_req & d_ok;

  // pick the side that lost the last conflict
  always_comb begin
    if_win = if_req & ~(d_ok & rr_d_q);
    d_win  = d_ok & ~(if_req & ~rr_d_q);
  end

  // pointer moves to the loser on conflict cycles only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rr_d_q <= 1'b0;
    else if (conflict) rr_d_q <= ~rr_d_q;
  end
`else
  // fixed priority: data side always wins
  always_comb begin
    if_win = if_req & ~d_ok;
    d_win  = d_ok;
  end
`endif

  // grants and memory command for the current cycle
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    d_err     = 1'b0;
    stall     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_f3    = f3_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (!rst) begin
      if_gnt = if_win;
      d_gnt  = d_win | d_bad;
      d_err  = d_bad;
      stall  = (if_req & ~if_win) | (d_ok & ~d_win);
      unique case (1'b1)
        d_win: begin
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_f3    = d_f3;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
        end
        if_win: begin
          mem_en   = 1'b1;
          mem_f3   = F3_W;
          mem_addr = if_addr;
        end
        default: ;
      endcase
    end
  end

  // keep the last command so idle cycles hold the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else if (mem_en) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      f3_q    <= mem_f3;
    end
  end

  // who gets next cycle's read data
  always_comb begin
    owner_d = IDLE;
    unique case (1'b1)
      if_win:  owner_d = OWN_IF;
      d_win:   owner_d = OWN_D;
      default: owner_d = IDLE;
    endcase
  end

  // owner register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner_q <= IDLE;
    else     owner_q <= owner_d;
  end

  assign if_valid = (owner_q == OWN_IF);
  assign d_valid  = (owner_q == OWN_D);
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign d_rdata  = d_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grants, responses,
// misalignment, conflicts and reset for mem_arbiter.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_gnt, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic d_req, d_we, d_gnt, d_valid, d_err;
  logic [2:0] d_f3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic mem_en, mem_we, stall;
  logic [2:0] mem_f3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errs = 0;
  int checks = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_f3(d_f3),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_f3(mem_f3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    if_req = 1; if_addr = 32'h4; d_req = 1; d_f3 = 3'd2;
    d_addr = 32'h44; d_we = 1; d_wdata = 32'h1234;
    #1;
    checks++; if (if_gnt !== 1'b0) begin errs++; $display("FAIL rst_if_gnt got %b want 0", if_gnt); end
    checks++; if (d_gnt !== 1'b0) begin errs++; $display("FAIL rst_d_gnt got %b want 0", d_gnt); end
    checks++; if (mem_en !== 1'b0) begin errs++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errs++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errs++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (mem_f3 !== 3'd0) begin errs++; $display("FAIL rst_mem_f3 got %h want 0", mem_f3); end
    checks++; if ({if_valid, d_valid, d_err, stall} !== 4'b0) begin errs++; $display("FAIL rst_flags got %b want 0000", {if_valid, d_valid, d_err, stall}); end
    checks++; if ({if_rdata, d_rdata} !== 64'h0) begin errs++; $display("FAIL rst_rdata got %h want 0", {if_rdata, d_rdata}); end
    @(negedge clk);
    rst = 0; if_req = 0; d_req = 0; d_we = 0;
  endtask

  task automatic test_conflict();
    @(negedge clk);
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_f3 = 3'd2; d_addr = 32'h80;
    #1;
    checks++; if (if_gnt !== RR) begin errs++; $display("FAIL cf_if_gnt got %b want %b", if_gnt, RR); end
    checks++; if (d_gnt !== !RR) begin errs++; $display("FAIL cf_d_gnt got %b want %b", d_gnt, !RR); end
    checks++; if (stall !== 1'b1) begin errs++; $display("FAIL cf_stall got %b want 1", stall); end
    checks++; if (mem_addr !== (RR ? 32'h40 : 32'h80)) begin errs++; $display("FAIL cf_addr got %h", mem_addr); end
    @(negedge clk);
    if_req = !RR; d_req = RR; mem_rdata = 32'h1111_2222;
    #1;
    checks++; if (if_gnt !== !RR) begin errs++; $display("FAIL cf2_if_gnt got %b want %b", if_gnt, !RR); end
    checks++; if (d_gnt !== RR) begin errs++; $display("FAIL cf2_d_gnt got %b want %b", d_gnt, RR); end
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL cf2_stall got %b want 0", stall); end
    checks++; if (if_valid !== RR || d_valid !== !RR) begin errs++; $display("FAIL cf2_valid got %b%b", if_valid, d_valid); end
    checks++; if (if_rdata !== (RR ? 32'h1111_2222 : 32'h0)) begin errs++; $display("FAIL cf2_if_rdata got %h", if_rdata); end
    checks++; if (d_rdata !== (RR ? 32'h0 : 32'h1111_2222)) begin errs++; $display("FAIL cf2_d_rdata got %h", d_rdata); end
    @(negedge clk);
    if_req = 0; d_req = 0; mem_rdata = 32'h3333_4444;
    #1;
    checks++; if (if_valid !== !RR || d_valid !== RR) begin errs++; $display("FAIL cf3_valid got %b%b", if_valid, d_valid); end
  endtask

  task automatic test_if_fetch();
    @(negedge clk);
    if_req = 1; if_addr = 32'h10;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errs++; $display("FAIL if_gnt got %b want 1", if_gnt); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errs++; $display("FAIL if_en_we got %b%b want 10", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h10) begin errs++; $display("FAIL if_addr got %h want 10", mem_addr); end
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL if_stall got %b want 0", stall); end
    @(negedge clk);
    if_req = 0; mem_rdata = 32'h0050_0093;
    #1;
    checks++; if (if_valid !== 1'b1) begin errs++; $display("FAIL if_valid got %b want 1", if_valid); end
    checks++; if (if_rdata !== 32'h0050_0093) begin errs++; $display("FAIL if_rdata got %h want 00500093", if_rdata); end
    checks++; if (d_valid !== 1'b0 || d_rdata !== 32'h0) begin errs++; $display("FAIL if_dside got %b %h want 0 0", d_valid, d_rdata); end
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req = 1; d_we = 1; d_f3 = 3'd2; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b1) begin errs++; $display("FAIL st_gnt got %b%b want 11", d_gnt, mem_en); end
    checks++; if (mem_we !== 1'b1) begin errs++; $display("FAIL st_we got %b want 1", mem_we); end
    checks++; if (mem_addr !== 32'h20) begin errs++; $display("FAIL st_addr got %h want 20", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL st_wdata got %h want deadbeef", mem_wdata); end
    checks++; if (mem_f3 !== 3'd2) begin errs++; $display("FAIL st_f3 got %h want 2", mem_f3); end
    @(negedge clk);
    d_req = 0; d_we = 0; mem_rdata = 32'h0;
    #1;
    checks++; if (d_valid !== 1'b1) begin errs++; $display("FAIL st_valid got %b want 1", d_valid); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errs++; $display("FAIL idle_en_we got %b%b want 00", mem_en, mem_we); end
    checks++; if (mem_addr !== 32'h20) begin errs++; $display("FAIL idle_addr got %h want 20", mem_addr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL idle_wdata got %h want deadbeef", mem_wdata); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    d_req = 1; d_we = 0; d_f3 = 3'd2; d_addr = 32'h22;
    #1;
    checks++; if (d_gnt !== 1'b1 || d_err !== 1'b1) begin errs++; $display("FAIL mis_gnt_err got %b%b want 11", d_gnt, d_err); end
    checks++; if (mem_en !== 1'b0) begin errs++; $display("FAIL mis_en got %b want 0", mem_en); end
    @(negedge clk);
    d_req = 0;
    #1;
    checks++; if (d_valid !== 1'b0 || d_err !== 1'b0) begin errs++; $display("FAIL mis_valid got %b%b want 00", d_valid, d_err); end
    @(negedge clk);
    d_req = 1; d_f3 = 3'd1; d_addr = 32'h31;
    if_req = 1; if_addr = 32'h13;
    #1;
    checks++; if (d_err !== 1'b1 || d_gnt !== 1'b1) begin errs++; $display("FAIL mish_err got %b%b want 11", d_err, d_gnt); end
    checks++; if (if_gnt !== 1'b1 || mem_en !== 1'b1) begin errs++; $display("FAIL mish_if got %b%b want 11", if_gnt, mem_en); end
    checks++; if (mem_addr !== 32'h13) begin errs++; $display("FAIL mish_addr got %h want 13", mem_addr); end
    @(negedge clk);
    if_req = 0; d_addr = 32'h32; mem_rdata = 32'hA5A5_0001;
    #1;
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hA5A5_0001) begin errs++; $display("FAIL mish_rsp got %b %h", if_valid, if_rdata); end
    checks++; if (d_gnt !== 1'b1 || d_err !== 1'b0 || mem_en !== 1'b1) begin errs++; $display("FAIL half_ok got %b%b%b want 101", d_gnt, d_err, mem_en); end
    @(negedge clk);
    d_req = 0;
    #1;
    checks++; if (d_valid !== 1'b1) begin errs++; $display("FAIL half_valid got %b want 1", d_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_req = (i < 4);
      if_addr = 32'h100 + 32'(4 * i);
      mem_rdata = 32'hC000_0000 + 32'(i) - 32'd1;
      #1;
      if (i < 4) begin
        checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * i)) begin errs++; $display("FAIL b2b_gnt%0d got %b %h", i, if_gnt, mem_addr); end
      end
      if (i > 0) begin
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hC000_0000 + 32'(i) - 32'd1) begin errs++; $display("FAIL b2b_rsp%0d got %b %h", i, if_valid, if_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req = 0; d_req = 1; d_we = 0; d_f3 = 3'd2; d_addr = 32'h24;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errs++; $display("FAIL rm_gnt got %b want 1", d_gnt); end
    @(negedge clk);
    d_req = 0; mem_rdata = 32'h77; rst = 1;
    #1;
    checks++; if (d_valid !== 1'b0 || d_rdata !== 32'h0) begin errs++; $display("FAIL rm_valid got %b %h want 0 0", d_valid, d_rdata); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0 || mem_f3 !== 3'd0) begin errs++; $display("FAIL rm_cmd got %h %h %h want 0", mem_addr, mem_wdata, mem_f3); end
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (d_valid !== 1'b0 || mem_addr !== 32'h0) begin errs++; $display("FAIL rm_after got %b %h want 0 0", d_valid, mem_addr); end
  endtask

  initial begin
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_f3 = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    test_reset();
    test_conflict();
    test_if_fetch();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
